// File: rtl/multiplicacao_datapath.sv
// multiplicacao_datapath
//   Shift-add multiplier datapath steered by an external control FSM.
//   Holds the operand, accumulator and iteration-counter registers.
//   Produces one partial product per clock and registers the final product.
//
// Ports
//   Clk, Rst        clock (rising edge), synchronous active-high reset
//   A, B            multiplicand / multiplier, loaded while limpaCont=1
//   limpaCont       clear counter/accumulator and load operands (idle)
//   ativCont        1 = hold counter, 0 = count
//   acumula         1 = hold acc/shift regs, 0 = accumulate and shift
//   Finalizado      fold the last partial product and capture Produto
//   contador        iteration counter, fed back to the FSM
//   Produto         registered 2*WIDTH-bit product
//   produto_valido  Produto holds the result of the latest completed run
//
// Configuration
//   MULT_SIGNED_EN  defined: two's-complement operands.  The multiplicand is
//                   sign-extended and the last partial product (multiplier
//                   MSB) is subtracted.  Undefined: unsigned.
//
// WIDTH must equal 2**CNT_W so the counter spans exactly one pass.
module multiplicacao_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               limpaCont,
  input  logic               ativCont,
  input  logic               acumula,
  input  logic               Finalizado,
  output logic [CNT_W-1:0]   contador,
  output logic [2*WIDTH-1:0] Produto,
  output logic               produto_valido
);

  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic               vld_q,    vld_d;

  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] a_ext;

`ifdef MULT_SIGNED_EN
  assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
`else
  assign a_ext = {{WIDTH{1'b0}}, A};
`endif

  assign pp = mplier_q[0] ? mcand_q : '0;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    vld_d    = vld_q;
    if (limpaCont) begin
      // Idle: operands follow the inputs every cycle; Produto holds.
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a_ext;
      mplier_d = B;
    end else begin
      // The three strobes act independently; conflicting combinations are
      // executed literally.
      if (!acumula) begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      if (!ativCont) begin
        cnt_d = cnt_q + CNT_W'(1);
        vld_d = 1'b0;
      end
      // The multiplier MSB is consumed only here; in signed mode it carries
      // negative weight.  Placed last so a capture always marks Produto valid.
      if (Finalizado) begin
`ifdef MULT_SIGNED_EN
        prod_d = acc_q - pp;
`else
        prod_d = acc_q + pp;
`endif
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      vld_q    <= vld_d;
    end
  end

  assign contador       = cnt_q;
  assign Produto        = prod_q;
  assign produto_valido = vld_q;

endmodule

// File: tb/tb_multiplicacao_datapath.sv
module tb_multiplicacao_datapath;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  A, B;
  logic        limpaCont, ativCont, acumula, Finalizado;
  logic [2:0]  contador;
  logic [15:0] Produto;
  logic        produto_valido;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] last_prod;
  logic        last_vld;

  multiplicacao_datapath #(.WIDTH(8), .CNT_W(3)) dut (
    .Clk(Clk), .Rst(Rst), .A(A), .B(B),
    .limpaCont(limpaCont), .ativCont(ativCont), .acumula(acumula),
    .Finalizado(Finalizado), .contador(contador), .Produto(Produto),
    .produto_valido(produto_valido)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product: plain integer multiply reduced modulo 2**16.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
`ifdef MULT_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[15:0];
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic set_idle();
    limpaCont = 1'b1; ativCont = 1'b1; acumula = 1'b1; Finalizado = 1'b0;
  endtask

  task automatic set_count();
    limpaCont = 1'b0; ativCont = 1'b0; acumula = 1'b0; Finalizado = 1'b0;
  endtask

  // One complete run as the paired FSM would sequence it.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [15:0] exp;
    exp = ref_mul(a, b);
    // A junk idle cycle first: only the operands at the leave-idle edge count.
    set_idle(); A = 8'($urandom); B = 8'($urandom);
    tick();
    chk({tag, ".idle_prod"}, 32'(Produto), 32'(last_prod));
    chk({tag, ".idle_vld"}, 32'(produto_valido), 32'(last_vld));
    A = a; B = b;
    tick();                                   // E0
    A = 8'($urandom); B = 8'($urandom);       // must not affect the run
    chk({tag, ".cnt0"}, 32'(contador), 0);
    for (int i = 0; i < 7; i++) begin
      set_count();
      tick();                                 // E1..E7
      chk({tag, ".cnt"}, 32'(contador), 32'(i + 1));
      chk({tag, ".vld_drop"}, 32'(produto_valido), 0);
    end
    limpaCont = 1'b0; ativCont = 1'b1; acumula = 1'b1; Finalizado = 1'b1;
    tick();                                   // E8
    chk({tag, ".prod"}, 32'(Produto), 32'(exp));
    chk({tag, ".vld"}, 32'(produto_valido), 1);
    chk({tag, ".cnt_hold"}, 32'(contador), 7);
    last_prod = exp; last_vld = 1'b1;
    set_idle();
  endtask

  initial begin
    Rst = 1'b1; A = '0; B = '0;
    set_idle();
    tick(); tick();
    chk("rst.cnt", 32'(contador), 0);
    chk("rst.prod", 32'(Produto), 0);
    chk("rst.vld", 32'(produto_valido), 0);
    Rst = 1'b0;
    last_prod = '0; last_vld = 1'b0;

    run(8'd13, 8'd11, "d13x11");
    run(8'd255, 8'd255, "d255x255");
    run(8'd0, 8'hA5, "d0xA5");
    run(8'hFD, 8'h05, "dFDx05");
    run(8'h80, 8'h80, "d80x80");
    run(8'h7F, 8'h81, "d7Fx81");

    // Back-to-back runs; Produto holds across several idle cycles.
    run(8'd6, 8'd7, "b2b1");
    for (int i = 0; i < 3; i++) begin
      A = 8'($urandom); B = 8'($urandom); tick();
      chk("b2b.hold", 32'(Produto), 32'(last_prod));
    end
    run(8'd9, 8'd9, "b2b2");

    // limpaCont beats Finalizado: no capture.
    limpaCont = 1'b1; Finalizado = 1'b1; A = 8'd3; B = 8'd3;
    tick();
    chk("clr_fin.prod", 32'(Produto), 32'(last_prod));
    chk("clr_fin.vld", 32'(produto_valido), 1);
    chk("clr_fin.cnt", 32'(contador), 0);
    set_idle();

    // Counter wraps 7 -> 0 if counting continues past the end.
    tick();
    for (int i = 0; i < 8; i++) begin set_count(); tick(); end
    chk("wrap.cnt", 32'(contador), 0);
    chk("wrap.vld", 32'(produto_valido), 0);
    last_vld = 1'b0;
    set_idle(); tick();

    // Reset mid-run at contador=4.
    run(8'd21, 8'd3, "pre_rst");
    A = 8'd50; B = 8'd60; tick();
    for (int i = 0; i < 4; i++) begin set_count(); tick(); end
    chk("mid.cnt4", 32'(contador), 4);
    Rst = 1'b1; tick(); Rst = 1'b0;
    chk("mid.cnt", 32'(contador), 0);
    chk("mid.prod", 32'(Produto), 0);
    chk("mid.vld", 32'(produto_valido), 0);
    last_prod = '0; last_vld = 1'b0;
    set_idle(); tick();

    for (int k = 0; k < 20; k++)
      run(8'($urandom), 8'($urandom), "rnd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
